// File: rtl/isw_dup_mul_ctrl_pkg.sv
// Shared types and constants for the duplicated ISW multiplier sequencer.
//   state_t     : controller FSM states (flush after reset, run, locked)
//   result_t    : one output FIFO entry (result shares + fault flag)
//   make_result : turns a retiring datapath sample into a FIFO entry
package isw_dup_mul_ctrl_pkg;

  localparam int SHARES       = 2;  // first-order masking, d = 1
  localparam int RAND_W       = 1;  // fresh random bits per multiplication
  localparam int LATENCY      = 2;  // multiplier issue-to-result cycles
  localparam int FIFO_DEPTH   = 4;  // output entries, also the issue credit limit
  localparam int FAULT_THRESH = 3;  // detected faults that lock the block
  localparam int CNT_W        = 8;  // fault counter width

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_RUN,
    ST_LOCK
  } state_t;

  typedef struct packed {
    logic [SHARES-1:0] res;
    logic              fault;
  } result_t;

  // A result is trusted only when both copies agree on every share;
  // anything else is zeroized so no partially faulty share leaves the block.
  function automatic result_t make_result(input logic [SHARES-1:0] res,
                                          input logic [SHARES-1:0] det);
    result_t r;
    r.fault = ~&det;
    r.res   = r.fault ? '0 : res;
    return r;
  endfunction

endpackage

// File: rtl/isw_dup_mul_ctrl_if.sv
// Bus bundle of the sequencer: operand input handshake, drive/return lines of
// the duplicated multiplier, result output handshake and status.
//   slave  : the sequencer's view
//   master : the environment's view (operand source, multipliers, consumer)
interface isw_dup_mul_ctrl_if;
  import isw_dup_mul_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [SHARES-1:0] in_a;
  logic [SHARES-1:0] in_b;
  logic [RAND_W-1:0] in_rand;

  logic [SHARES-1:0] mul_a;
  logic [SHARES-1:0] mul_b;
  logic [RAND_W-1:0] mul_rand;
  logic [SHARES-1:0] mul_res;
  logic [SHARES-1:0] mul_det;

  logic              out_valid;
  logic              out_ready;
  logic [SHARES-1:0] out_res;
  logic              out_fault;
  logic [CNT_W-1:0]  fault_cnt;
  logic              alarm;

  modport slave (
    input  in_valid, in_a, in_b, in_rand, mul_res, mul_det, out_ready,
    output in_ready, mul_a, mul_b, mul_rand, out_valid, out_res, out_fault,
           fault_cnt, alarm
  );

  modport master (
    output in_valid, in_a, in_b, in_rand, mul_res, mul_det, out_ready,
    input  in_ready, mul_a, mul_b, mul_rand, out_valid, out_res, out_fault,
           fault_cnt, alarm
  );

endinterface

// File: rtl/isw_dup_mul_ctrl_fifo.sv
// isw_result_fifo: synchronous FIFO holding retired results.
//   clk, reset (sync, active-low) ; wr_en/wr_data push ; rd_en pops the head
//   rd_data : current head (valid while empty=0) ; empty ; count = occupancy
module isw_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the pointers, so stale entries are never observed and the array can map
  // onto plain registers or RAM without reset muxes.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leaves occupancy unchanged.
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue credits guarantee room for every retiring result.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(wr_en && full));

endmodule

// File: rtl/isw_dup_mul_ctrl.sv
// isw_dup_mul_ctrl: sequencer for a duplicated first-order ISW multiplier.
//   clk, reset (sync, active-low)
//   bus.in_*   : operand shares + fresh randomness, valid/ready
//   bus.mul_*  : operands to both multiplier copies, result + detector back
//   bus.out_*  : result FIFO head, valid/ready; out_res zeroized on fault
//   bus.fault_cnt : saturating count of detected faults
//   bus.alarm  : high while locked
module isw_dup_mul_ctrl
  import isw_dup_mul_ctrl_pkg::*;
(
  input logic               clk,
  input logic               reset,
  isw_dup_mul_ctrl_if.slave bus
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = $clog2(FIFO_DEPTH + LATENCY + 1);
  localparam int FLW = $clog2(LATENCY + 1);

  state_t             state, state_nxt;
  logic [FLW-1:0]     flush_cnt;
  logic [LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]   fault_cnt, fault_cnt_nxt;
  logic [FCW-1:0]     fifo_count;
  logic [CRW-1:0]     inflight, credit_used;
  logic               in_ready, alarm, accept, retire, pop, fifo_empty;
  result_t            push_data, head;

  // ---------------- FSM: state register ----------------
  // The multiplier pipeline has no reset, so the controller waits LATENCY
  // cycles for any garbage in it to drain before accepting work.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_FLUSH;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FLUSH: if (flush_cnt == FLW'(LATENCY - 1)) state_nxt = ST_RUN;
      // Lock on the very edge the counter reaches the threshold.
      ST_RUN:   if (fault_cnt_nxt >= CNT_W'(FAULT_THRESH)) state_nxt = ST_LOCK;
      ST_LOCK:  state_nxt = ST_LOCK;
      default:  state_nxt = ST_FLUSH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Credits count ops in the pipe plus entries in the FIFO, all registered,
  // so in_ready has no combinational path from out_ready.
  always_comb begin
    in_ready = 1'b0;
    alarm    = 1'b0;
    unique case (state)
      ST_RUN:  in_ready = (credit_used < CRW'(FIFO_DEPTH));
      ST_LOCK: alarm    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CRW'(vld_sr[i]);
  end

  assign credit_used = inflight + CRW'(fifo_count);

  // ---------------- Issue ----------------
  // Operands reach the multipliers only on an accepted handshake; idle cycles
  // present zeros so no stale share values toggle the datapath.
  assign accept       = bus.in_valid && in_ready;
  assign bus.mul_a    = accept ? bus.in_a    : '0;
  assign bus.mul_b    = accept ? bus.in_b    : '0;
  assign bus.mul_rand = accept ? bus.in_rand : '0;

  always_ff @(posedge clk) begin
    if (!reset) vld_sr <= '0;
    else        vld_sr <= (vld_sr << 1) | LATENCY'(accept);
  end

  // ---------------- Retire ----------------
  assign retire    = vld_sr[LATENCY-1];
  assign push_data = make_result(bus.mul_res, bus.mul_det);

  assign fault_cnt_nxt = (retire && push_data.fault && (fault_cnt != '1))
                         ? fault_cnt + 1'b1 : fault_cnt;

  always_ff @(posedge clk) begin
    if (!reset) fault_cnt <= '0;
    else        fault_cnt <= fault_cnt_nxt;
  end

  // ---------------- Output FIFO ----------------
  assign pop = !fifo_empty && bus.out_ready;

  isw_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(result_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (retire),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The FIFO array is not reset, so the head is masked while empty.
  assign bus.out_valid = !fifo_empty;
  assign bus.out_res   = fifo_empty ? '0   : head.res;
  assign bus.out_fault = fifo_empty ? 1'b0 : head.fault;
  assign bus.in_ready  = in_ready;
  assign bus.alarm     = alarm;
  assign bus.fault_cnt = fault_cnt;

endmodule

// File: tb/tb_isw_dup_mul_ctrl.sv
// Scoreboard bench for isw_dup_mul_ctrl with a behavioural model of the
// duplicated 2-cycle ISW multiplier and per-op fault injection on mul_det.
module tb_isw_dup_mul_ctrl;
  import isw_dup_mul_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  isw_dup_mul_ctrl_if bus ();

  isw_dup_mul_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       r;
    logic [1:0] res;   // hand-computed result shares {c1, c0}
  } vec_t;

  // c0 = a0b0 ^ r ; c1 = a1b1 ^ (r ^ a0b1) ^ a1b0
  function automatic vec_t vec(input int i);
    case (i % 8)
      0: return '{a: 2'b01, b: 2'b11, r: 1'b1, res: 2'b00};
      1: return '{a: 2'b10, b: 2'b01, r: 1'b0, res: 2'b10};
      2: return '{a: 2'b11, b: 2'b11, r: 1'b0, res: 2'b11};
      3: return '{a: 2'b01, b: 2'b10, r: 1'b1, res: 2'b01};
      4: return '{a: 2'b10, b: 2'b10, r: 1'b1, res: 2'b01};
      5: return '{a: 2'b00, b: 2'b11, r: 1'b1, res: 2'b11};
      6: return '{a: 2'b11, b: 2'b01, r: 1'b1, res: 2'b00};
      default: return '{a: 2'b01, b: 2'b01, r: 1'b0, res: 2'b01};
    endcase
  endfunction

  function automatic logic [1:0] isw_mul(input logic [1:0] a, input logic [1:0] b,
                                         input logic r);
    logic c0, c1;
    c0 = (a[0] & b[0]) ^ r;
    c1 = (a[1] & b[1]) ^ (r ^ (a[0] & b[1])) ^ (a[1] & b[0]);
    return {c1, c0};
  endfunction

  int      checks = 0;
  int      errors = 0;
  result_t sb[$];
  int      mon_faults = 0;
  bit      track_cnt = 1'b0;
  logic    inj_cur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier pair model ----------------
  logic [1:0] mul_cap = '0, st1 = '0, st2 = '0;
  logic       tag_cap = 1'b0, f1 = 1'b0, f2 = 1'b0;

  always @(negedge clk) begin
    mul_cap = isw_mul(bus.mul_a, bus.mul_b, bus.mul_rand[0]);
    tag_cap = bus.in_valid & bus.in_ready & inj_cur;
  end

  always @(posedge clk) begin
    st1 <= mul_cap;
    st2 <= st1;
    f1  <= tag_cap;
    f2  <= f1;
  end

  assign bus.mul_res = st2;
  assign bus.mul_det = f2 ? 2'b10 : 2'b11;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    result_t e;
    if (reset) begin
      check("mul_gate", {bus.mul_a, bus.mul_b, bus.mul_rand},
            (bus.in_valid && bus.in_ready) ? {bus.in_a, bus.in_b, bus.in_rand} : 5'b0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("out_unexpected", bus.out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_res", bus.out_res, e.res);
          check("out_fault", bus.out_fault, e.fault);
          if (e.fault) mon_faults++;
          if (track_cnt) begin
            check("fault_cnt_track", bus.fault_cnt, mon_faults);
            check("alarm_track", bus.alarm, mon_faults >= FAULT_THRESH);
          end
        end
      end else if (!bus.out_valid) begin
        check("out_idle_zero", {bus.out_res, bus.out_fault}, 3'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_vec(input int i);
    vec_t v;
    v = vec(i);
    bus.in_a    = v.a;
    bus.in_b    = v.b;
    bus.in_rand = v.r;
  endtask

  task automatic push_exp(input int i, input logic inj);
    result_t e;
    vec_t    v;
    v       = vec(i);
    e.res   = inj ? 2'b00 : v.res;
    e.fault = inj;
    sb.push_back(e);
  endtask

  // Offers one op; returns at #1 after the accepting edge.
  task automatic send(input int i, input logic inj);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    drive_vec(i);
    inj_cur = inj;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(i, inj);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_rand = '0;
    inj_cur = 1'b0;
    check("send_accepted", ok, 1'b1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    check("drain_done", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    mon_faults = 0;
  endtask

  // Called in the first cycle after the last reset edge.
  task automatic post_reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_in_ready0"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, {bus.out_res, bus.out_fault}, 3'b0);
    check({tag, "_fault_cnt"}, bus.fault_cnt, 8'd0);
    check({tag, "_alarm"}, bus.alarm, 1'b0);
    check({tag, "_mul_zero"}, {bus.mul_a, bus.mul_b, bus.mul_rand}, 5'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_in_ready1"}, bus.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_in_ready2"}, bus.in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rand   = '0;
    bus.out_ready = 1'b1;

    // 1: reset, flush window, idle
    do_reset(3);
    post_reset_checks("t1");
    repeat (3) begin
      @(negedge clk);
      check("t1_idle", {bus.in_ready, bus.out_valid}, 2'b10);
      @(posedge clk); #1;
    end

    // 2: single op, latency LATENCY+1
    track_cnt = 1'b1;
    send(0, 1'b0);
    @(negedge clk); check("t2_lat1", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); check("t2_lat2", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); check("t2_lat3", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    wait_drain();

    // 3: back-pressure fills credits, then drain in order
    track_cnt = 1'b0;
    bus.out_ready = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_vec(acc);
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(acc, 1'b0);
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("t3_accepts", acc, 4);
    @(negedge clk); check("t3_blocked", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();
    @(negedge clk); check("t3_ready_back", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // 4: single injected fault between healthy neighbours
    track_cnt = 1'b1;
    send(4, 1'b0);
    send(5, 1'b1);
    send(6, 1'b0);
    wait_drain();
    @(negedge clk); check("t4_fault_cnt", bus.fault_cnt, 8'd1);
    @(posedge clk); #1;

    // 5: three faults lock; in-flight ops still emerge
    do_reset(1);
    post_reset_checks("t5r");
    send(7, 1'b1);
    send(0, 1'b1);
    send(1, 1'b1);
    send(2, 1'b0);
    send(3, 1'b0);
    wait_drain();
    @(negedge clk);
    check("t5_alarm", bus.alarm, 1'b1);
    check("t5_fault_cnt", bus.fault_cnt, 8'd3);
    @(posedge clk); #1;
    acc = 0;
    bus.in_valid = 1'b1;
    drive_vec(4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("t5_locked_accepts", acc, 0);
    @(negedge clk); check("t5_still_alarm", bus.alarm, 1'b1);
    @(posedge clk); #1;
    do_reset(1);
    post_reset_checks("t5x");

    // 6: reset with ops both in flight and queued
    track_cnt = 1'b0;
    bus.out_ready = 1'b0;
    send(4, 1'b1);
    send(5, 1'b0);
    send(6, 1'b0);
    send(7, 1'b0);
    @(negedge clk);
    check("t6_pre_fault_cnt", bus.fault_cnt, 8'd1);
    check("t6_pre_out_valid", bus.out_valid, 1'b1);
    do_reset(1);
    post_reset_checks("t6");
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_output", bus.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
